// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-SRAM arbiter: FSM states, master indices,
// default SRAM region tag and the width of the read-latency counter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_e;

  localparam logic [15:0] DEF_REGION = 16'h1000;
  localparam logic        M0         = 1'b0;
  localparam logic        M1         = 1'b1;
  localparam int          CNT_W      = 3;

endpackage

// File: rtl/dmem_arbiter_arb.sv
// Two-requester combinational arbiter returning a one-hot grant; no latency, no state.
// DMEM_ARB_RR_EN selects round-robin on ties, otherwise m0 has fixed priority.
module arb_rr2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = (last_i == M1) ? 2'b01 : 2'b10;
    end
  end
`else
  // Fixed priority never looks at the grant history.
  logic unused_last;
  assign unused_last = last_i;

  always_comb begin
    gnt_o = req_i[M0] ? 2'b01 : req_i;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data SRAM between m0 and m1; ack after 2 (write), 2+RD_LAT (read) or 1 (error) cycles.
// Masters hold req until ack, the loser waits for the next IDLE; DMEM_ARB_RR_EN enables round-robin ties.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int          AW     = 14,
  parameter int          RD_LAT = 1,
  parameter logic [15:0] REGION = DEF_REGION
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [31:0]   m1_rdata,
  output logic          sram_en,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  state_e             state_q, state_d;
  logic               win_q, win_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         ack_q, ack_d;
  logic [1:0]         err_q, err_d;
  logic [31:0]        rd0_q, rd0_d, rd1_q, rd1_d;
  logic               sram_en_q, sram_en_d, sram_we_q, sram_we_d;
  logic [AW-1:0]      sram_addr_q, sram_addr_d;
  logic [31:0]        sram_wdata_q, sram_wdata_d;

  logic [1:0]         gnt;
  logic               sel;
  logic [31:0]        sel_addr, sel_wdata;
  logic               sel_we;
  logic               unused_addr;

  arb_rr2 u_arb (
    .req_i  ({m1_req, m0_req}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign sel       = gnt[M1];
  assign sel_addr  = sel ? m1_addr  : m0_addr;
  assign sel_wdata = sel ? m1_wdata : m0_wdata;
  assign sel_we    = sel ? m1_we    : m0_we;
  // Byte-offset bits and in-region bits above the word index are don't-care.
  assign unused_addr = ^sel_addr;

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    ack_d        = '0;
    err_d        = '0;
    rd0_d        = '0;
    rd1_d        = '0;
    sram_en_d    = 1'b0;
    sram_we_d    = 1'b0;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          win_d  = sel;
          last_d = sel;
          if (sel_addr[31:16] == REGION) begin
            state_d      = ISSUE;
            sram_en_d    = 1'b1;
            sram_we_d    = sel_we;
            sram_addr_d  = sel_addr[AW+1:2];
            sram_wdata_d = sel_wdata;
          end else begin
            state_d    = ACK;
            ack_d[sel] = 1'b1;
            err_d[sel] = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (sram_we_q) begin
          state_d      = ACK;
          ack_d[win_q] = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(RD_LAT);
        end
      end
      WAIT: begin
        // Count 1 marks the cycle the SRAM presents data for the ISSUE strobe.
        if (cnt_q == CNT_W'(1)) begin
          state_d      = ACK;
          ack_d[win_q] = 1'b1;
          if (win_q == M1) rd1_d = sram_rdata;
          else             rd0_d = sram_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      win_q        <= M0;
      last_q       <= M1;
      cnt_q        <= '0;
      ack_q        <= '0;
      err_q        <= '0;
      rd0_q        <= '0;
      rd1_q        <= '0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rd0_q        <= rd0_d;
      rd1_q        <= rd1_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign m0_ack     = ack_q[M0];
  assign m1_ack     = ack_q[M1];
  assign m0_err     = err_q[M0];
  assign m1_err     = err_q[M1];
  assign m0_rdata   = rd0_q;
  assign m1_rdata   = rd1_q;
  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboarded bench for dmem_arbiter: a transaction-level model predicts grant order,
// SRAM strobes and ack timing; a negedge monitor compares everything the DUT emits.
module tb_dmem_arbiter;

  localparam int AW     = 14;
  localparam int RD_LAT = 2;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0]   m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata, sram_rdata;

  dmem_arbiter #(.AW(AW), .RD_LAT(RD_LAT), .REGION(16'h1000)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int m; bit err; logic [31:0] rdata; int t; } ack_t;
  typedef struct { bit we; logic [AW-1:0] addr; logic [31:0] wdata; int t; } sram_t;
  ack_t  exp_ack[$];
  sram_t exp_sram[$];

  int  checks = 0, errors = 0;
  bit  mon_en = 1'b0;
  bit  last_m = 1'b1;
  logic [31:0] ref_mem [2**AW];

  // SRAM environment: synchronous array, read data RD_LAT cycles after the strobe, noise otherwise.
  logic [31:0] sram_mem [2**AW];
  logic [31:0] pipe [RD_LAT];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 2**AW; i++) sram_mem[i] <= '0;
      mem_init <= 1'b1;
    end else if (sram_en && sram_we) begin
      sram_mem[sram_addr] <= sram_wdata;
    end
    for (int i = RD_LAT-1; i > 0; i--) pipe[i] <= pipe[i-1];
    if (sram_en && !sram_we) pipe[0] <= sram_mem[sram_addr];
    else                     pipe[0] <= $urandom;
  end
  assign sram_rdata = pipe[RD_LAT-1];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  task automatic mon_ack(input int m, input logic ack, input logic err, input logic [31:0] rd);
    ack_t e;
    if (ack) begin
      if (exp_ack.size() == 0) begin
        checks++; errors++;
        $display("FAIL m%0d_ack_unexpected: got ack at cycle %0d expected none", m, cyc);
      end else begin
        e = exp_ack.pop_front();
        chk($sformatf("ack_master"), m, e.m);
        chk($sformatf("m%0d_err", m), err, e.err);
        chk($sformatf("m%0d_rdata", m), rd, e.rdata);
        chk($sformatf("m%0d_ack_cycle", m), cyc, e.t);
      end
    end else begin
      chk($sformatf("m%0d_quiet", m), {err, rd}, 0);
    end
  endtask

  always @(negedge clk) begin
    sram_t s;
    if (mon_en) begin
      if (sram_en) begin
        if (exp_sram.size() == 0) begin
          checks++; errors++;
          $display("FAIL sram_en_unexpected: got strobe at cycle %0d addr %0h expected none", cyc, sram_addr);
        end else begin
          s = exp_sram.pop_front();
          chk("sram_we", sram_we, s.we);
          chk("sram_addr", sram_addr, s.addr);
          chk("sram_wdata", sram_wdata, s.wdata);
          chk("sram_cycle", cyc, s.t);
        end
      end else begin
        chk("sram_we_idle", sram_we, 0);
      end
      mon_ack(0, m0_ack, m0_err, m0_rdata);
      mon_ack(1, m1_ack, m1_err, m1_rdata);
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {m0_ack, m1_ack, m0_err, m1_err, sram_en, sram_we}, 0);
    chk({tag, "_m0_rdata"}, m0_rdata, 0);
    chk({tag, "_m1_rdata"}, m1_rdata, 0);
    chk({tag, "_sram_addr"}, sram_addr, 0);
    chk({tag, "_sram_wdata"}, sram_wdata, 0);
  endtask

  // Each master issues n accesses back to back with fixed attributes, holding req until its last ack.
  task automatic run(input int n0, input int n1, input bit we0, input bit we1,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1);
    int rem[2];
    bit we[2];
    logic [31:0] a[2], d[2];
    logic [AW-1:0] idx;
    int t, m, c0, c1, budget;
    @(negedge clk);
    rem = '{n0, n1}; we = '{we0, we1}; a = '{a0, a1}; d = '{d0, d1};
    t = cyc;
    while (rem[0] > 0 || rem[1] > 0) begin
      if (rem[0] > 0 && rem[1] > 0) m = (RR && last_m == 1'b0) ? 1 : 0;
      else                          m = (rem[0] > 0) ? 0 : 1;
      last_m = m[0];
      idx = a[m][AW+1:2];
      if (a[m][31:16] != 16'h1000) begin
        exp_ack.push_back('{m, 1'b1, 32'h0, t + 1});
        t = t + 2;
      end else begin
        exp_sram.push_back('{we[m], idx, d[m], t + 1});
        if (we[m]) begin
          ref_mem[idx] = d[m];
          exp_ack.push_back('{m, 1'b0, 32'h0, t + 2});
          t = t + 3;
        end else begin
          exp_ack.push_back('{m, 1'b0, ref_mem[idx], t + 2 + RD_LAT});
          t = t + 3 + RD_LAT;
        end
      end
      rem[m]--;
    end
    m0_we = we0; m0_addr = a0; m0_wdata = d0; m0_req = (n0 > 0);
    m1_we = we1; m1_addr = a1; m1_wdata = d1; m1_req = (n1 > 0);
    c0 = 0; c1 = 0; budget = 0;
    while ((c0 < n0 || c1 < n1) && budget < 200) begin
      @(negedge clk);
      budget++;
      if (m0_ack) begin c0++; if (c0 >= n0) m0_req = 1'b0; end
      if (m1_ack) begin c1++; if (c1 >= n1) m1_req = 1'b0; end
    end
    if (budget >= 200) begin
      checks++; errors++;
      $display("FAIL run_timeout: got acks m0=%0d m1=%0d expected m0=%0d m1=%0d", c0, c1, n0, n1);
      m0_req = 1'b0; m1_req = 1'b0;
      reset = 1'b1; @(negedge clk); reset = 1'b0;
      exp_ack.delete(); exp_sram.delete(); last_m = 1'b1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) != 0) r = {16'h1000, 10'h0, r[5:0]};
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int n0, n1;
    bit w0, w1;
    logic [31:0] ra0, ra1, rd0, rd1;
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    mon_en = 1'b1;

    run(1, 0, 1'b1, 1'b0, 32'h1000_0010, 32'h0, 32'hDEAD_BEEF, 32'h0);
    run(0, 1, 1'b0, 1'b0, 32'h0, 32'h1000_0010, 32'h0, 32'h1234_5678);
    run(1, 0, 1'b0, 1'b0, 32'hA000_0000, 32'h0, 32'h0, 32'h0);
    run(1, 0, 1'b1, 1'b0, 32'h1001_0004, 32'h0, 32'h5555_AAAA, 32'h0);
    run(0, 1, 1'b1, 1'b0, 32'h0, 32'h1000_FFFC, 32'h0, 32'hCAFE_F00D);
    run(1, 0, 1'b0, 1'b0, 32'h1000_FFFE, 32'h0, 32'h0, 32'h0);
    run(1, 1, 1'b1, 1'b0, 32'h1000_0020, 32'h1000_0020, 32'h0BAD_F00D, 32'h0);

    // Abandon an m0 read in WAIT; the model expects its strobe but never its ack.
    @(negedge clk);
    m0_we = 1'b0; m0_addr = 32'h1000_0010; m0_wdata = 32'h0; m0_req = 1'b1;
    exp_sram.push_back('{1'b0, 14'd4, 32'h0, cyc + 1});
    repeat (2) @(negedge clk);
    reset = 1'b1; m0_req = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    reset = 1'b0;
    last_m = 1'b1;
    repeat (4) @(negedge clk);
    run(4, 4, 1'b1, 1'b1, 32'h1000_0100, 32'h1000_0200, 32'h1111_1111, 32'h2222_2222);

    repeat (60) begin
      n0 = $urandom_range(0, 2);
      n1 = $urandom_range(0, 2);
      if (n0 == 0 && n1 == 0) n0 = 1;
      w0 = 1'($urandom_range(0, 1));
      w1 = 1'($urandom_range(0, 1));
      ra0 = rand_addr(); ra1 = rand_addr();
      rd0 = $urandom;    rd1 = $urandom;
      run(n0, n1, w0, w1, ra0, ra1, rd0, rd1);
    end

    repeat (6) @(negedge clk);
    chk("ack_queue_drained", exp_ack.size(), 0);
    chk("sram_queue_drained", exp_sram.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
